// File: rtl/ic_pkg.sv
// Shared types and default sizing for the interrupt scheduler slice.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } ic_state_e;

    localparam int DEF_N_IRQ       = 8;
    localparam int DEF_ID_W        = $clog2(DEF_N_IRQ);
    localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/ic_rr_arbiter.sv
// Picks one eligible request: lowest index in fixed mode, first index at or
// above the pointer (wrapping) in round-robin mode.
module ic_rr_arbiter #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_IRQ-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid
);

    logic [ID_W:0]   start;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        start       = mode ? {1'b0, ptr} : '0;
        sum         = '0;
        idx         = '0;
        // Scan N_IRQ positions starting at the pointer; first hit wins.
        for (int k = 0; k < N_IRQ; k++) begin
            sum = start + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_IRQ)) begin
                sum = sum - (ID_W+1)'(N_IRQ);
            end
            idx = sum[ID_W-1:0];
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/ic_irq_scheduler.sv
// Interrupt delivery sequencer: edge-detects requests into a pending register,
// arbitrates the masked set and runs the irq_out/ack handshake with a timeout.
module ic_irq_scheduler
    import ic_pkg::*;
#(
    parameter int N_IRQ       = DEF_N_IRQ,
    parameter int ID_W        = DEF_ID_W,
    parameter int ARB_RR      = 0,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_requests,
    input  logic [N_IRQ-1:0] mask_reg,
    input  logic             ack,
    input  logic             busy,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending_reg,
    output logic             timeout_err,
    output logic             spurious_ack
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic            RR_MODE  = (ARB_RR != 0);

    ic_state_e        state, state_n;
    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] pending_q, pending_n;
    logic [N_IRQ-1:0] clr_vec;
    logic [ID_W-1:0]  id_q, id_n;
    logic [ID_W-1:0]  ptr_q, ptr_n;
    logic [ID_W-1:0]  next_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ack_q;
    logic             timeout_n;
    logic             spurious_n;
    logic [ID_W-1:0]  grant_id;
    logic             grant_valid;

    ic_rr_arbiter #(
        .N_IRQ(N_IRQ),
        .ID_W (ID_W)
    ) u_arb (
        .eligible   (pending_q & mask_reg),
        .ptr        (ptr_q),
        .mode       (RR_MODE),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    assign next_ptr   = (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + ID_W'(1);
    assign spurious_n = ack && !ack_q && (state == IDLE);
    // A fresh edge on a bit being cleared this cycle keeps it pending.
    assign pending_n  = (pending_q & ~clr_vec) | (irq_requests & ~req_q);

    // Handshake: irq_out is the offer and stays high with irq_id stable until
    // ack is sampled high (accept), the line is masked, or the timeout expires;
    // after an accept irq_out stays low until ack and busy are both low.
    always_comb begin
        state_n   = state;
        id_n      = id_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        timeout_n = 1'b0;
        clr_vec   = '0;
        case (state)
            IDLE: begin
                if (grant_valid && !busy) begin
                    state_n = ASSERT;
                    id_n    = grant_id;
                    cnt_n   = '0;
                end
            end
            ASSERT: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (ack) begin
                    clr_vec[id_q] = 1'b1;
                    ptr_n         = next_ptr;
                    state_n       = SERVICE;
                end else if (!mask_reg[id_q]) begin
                    state_n = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_n = 1'b1;
                    ptr_n     = next_ptr;
                    state_n   = IDLE;
                end
            end
            SERVICE: begin
                if (!ack && !busy) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_q        <= '0;
            pending_q    <= '0;
            id_q         <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            timeout_err  <= 1'b0;
            spurious_ack <= 1'b0;
        end else begin
            state        <= state_n;
            req_q        <= irq_requests;
            pending_q    <= pending_n;
            id_q         <= id_n;
            ptr_q        <= ptr_n;
            cnt_q        <= cnt_n;
            ack_q        <= ack;
            timeout_err  <= timeout_n;
            spurious_ack <= spurious_n;
        end
    end

    assign irq_out     = (state == ASSERT);
    assign irq_id      = id_q;
    assign pending_reg = pending_q;

endmodule
